// File: rtl/sobel_window_feeder.sv
// 3x3 window feeder for the Sobel gradient unit: buffers two rows of a raster pixel
// stream, starts the gradient unit per interior pixel and returns its sum as a result stream.
// Optional WAIT timeout is built only when FEEDER_TIMEOUT_EN is defined.
module sobel_window_feeder #(
  parameter int IMG_WIDTH      = 16,
  parameter int IMG_HEIGHT     = 16,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pixel_valid,
  input  logic [7:0] i_pixel,
  output logic       o_pixel_ready,
  output logic       o_gradient_start,
  output logic [7:0] o_P0,
  output logic [7:0] o_P1,
  output logic [7:0] o_P2,
  output logic [7:0] o_P3,
  output logic [7:0] o_P4,
  output logic [7:0] o_P5,
  output logic [7:0] o_P6,
  output logic [7:0] o_P7,
  output logic [7:0] o_P8,
  input  logic       i_gradient_data_ready,
  input  logic [7:0] i_processed_sum,
  output logic       o_result_valid,
  output logic [7:0] o_result,
  input  logic       i_result_ready,
  output logic       o_frame_done,
  output logic       o_timeout_err
);

  // state  | meaning
  // IDLE   | accepting pixels; only state in which the window may shift
  // START  | one-cycle start pulse to the gradient unit
  // WAIT   | waiting for the gradient data-ready strobe
  // OUTPUT | result presented until the downstream accepts it
  typedef enum logic [1:0] {IDLE, START, WAIT, OUTPUT} state_t;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    line1 [IMG_WIDTH];
  logic [7:0]    line2 [IMG_WIDTH];
  logic [7:0]    win   [9];

  logic accept;
  logic win_valid;
  logic last_px;
  logic last_win;
  logic timeout_hit;

  assign o_pixel_ready = (state == IDLE) && !rst;
  assign accept        = i_pixel_valid && o_pixel_ready;
  assign win_valid     = (row >= RW'(2)) && (col >= CW'(2));
  assign last_px       = (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1));

  assign o_P0 = win[0];
  assign o_P1 = win[1];
  assign o_P2 = win[2];
  assign o_P3 = win[3];
  assign o_P4 = win[4];
  assign o_P5 = win[5];
  assign o_P6 = win[6];
  assign o_P7 = win[7];
  assign o_P8 = win[8];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    o_gradient_start = 1'b0;
    o_result_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && win_valid) state_nxt = START;
      end
      START: begin
        o_gradient_start = 1'b1;
        state_nxt        = WAIT;
      end
      WAIT: begin
        if (i_gradient_data_ready || timeout_hit) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        o_result_valid = 1'b1;
        if (i_result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window, line buffers and raster counters advance only on an accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        line1[i] <= '0;
        line2[i] <= '0;
      end
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= line2[col];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= line1[col];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= i_pixel;
      line2[col] <= line1[col];
      line1[col] <= i_pixel;
      if (col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // last_win remembers whether the window in flight closes the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_result     <= '0;
      last_win     <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= (state == OUTPUT) && i_result_ready && last_win;
      if (accept && win_valid) last_win <= last_px;
      if (state == WAIT) begin
        if (i_gradient_data_ready) o_result <= i_processed_sum;
        else if (timeout_hit)      o_result <= 8'd0;
      end
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_err_q;

  assign timeout_hit   = (state == WAIT) && !i_gradient_data_ready &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign o_timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed self-checking bench for sobel_window_feeder on a 4x4 image with a
// behavioural gradient unit that strobes 14 cycles after start and returns P4.
module tb_sobel_window_feeder;

  logic       clk;
  logic       rst;
  logic       i_pixel_valid;
  logic [7:0] i_pixel;
  logic       o_pixel_ready;
  logic       o_gradient_start;
  logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic       i_gradient_data_ready;
  logic [7:0] i_processed_sum;
  logic       o_result_valid;
  logic [7:0] o_result;
  logic       i_result_ready;
  logic       o_frame_done;
  logic       o_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic       model_en;
  logic       mdl_strobe;
  logic [7:0] mdl_sum;
  int         mdl_cnt;
  int         mdl_strobes;
  logic       man_strobe;
  logic [7:0] man_sum;

  int          n_start;
  int          n_fd;
  int          fd_at;
  int          first_after;
  logic [7:0]  last_acc;
  logic [71:0] first_win;
  logic [7:0]  results[$];

  assign i_gradient_data_ready = mdl_strobe | man_strobe;
  assign i_processed_sum       = man_strobe ? man_sum : mdl_sum;

  sobel_window_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .TIMEOUT_CYCLES(63)) dut (
    .clk(clk), .rst(rst),
    .i_pixel_valid(i_pixel_valid), .i_pixel(i_pixel), .o_pixel_ready(o_pixel_ready),
    .o_gradient_start(o_gradient_start),
    .o_P0(p0), .o_P1(p1), .o_P2(p2), .o_P3(p3), .o_P4(p4),
    .o_P5(p5), .o_P6(p6), .o_P7(p7), .o_P8(p8),
    .i_gradient_data_ready(i_gradient_data_ready), .i_processed_sum(i_processed_sum),
    .o_result_valid(o_result_valid), .o_result(o_result), .i_result_ready(i_result_ready),
    .o_frame_done(o_frame_done), .o_timeout_err(o_timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Gradient unit model: latches P4 at start, strobes 14 cycles later.
  initial begin
    mdl_cnt = 0; mdl_strobe = 0; mdl_sum = 0; mdl_strobes = 0;
    forever begin
      @(negedge clk);
      mdl_strobe = 0;
      if (o_gradient_start && model_en) begin
        mdl_cnt = 14;
        mdl_sum = p4;
      end else if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          mdl_strobe = 1;
          mdl_strobes++;
        end
      end
    end
  end

  // Observation only: records starts, accepted results and frame-done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (o_gradient_start) begin
        if (n_start == 0) begin
          first_win   = {p0, p1, p2, p3, p4, p5, p6, p7, p8};
          first_after = int'(last_acc);
        end
        n_start++;
      end
      if (o_result_valid && i_result_ready) results.push_back(o_result);
      if (o_frame_done) begin
        n_fd++;
        fd_at = results.size();
      end
      if (i_pixel_valid && o_pixel_ready) last_acc = i_pixel;
    end
  end

  task automatic clear_mon();
    n_start = 0; n_fd = 0; fd_at = -1; first_after = -1;
    first_win = '0; results.delete();
  endtask

  task automatic stream(input int first, input int last);
    int p = first;
    int budget = 0;
    while (p <= last && budget < 2000) begin
      i_pixel = p[7:0];
      i_pixel_valid = 1;
      @(negedge clk);
      if (o_pixel_ready) p++;
      @(posedge clk); #1;
      budget++;
    end
    i_pixel_valid = 0;
    n_tests++;
    if (p <= last) begin
      n_fail++;
      $display("FAIL stream_budget: stopped at pixel %0d, required all up to %0d", p, last);
    end
  endtask

  task automatic wait_done(input int n);
    int cyc = 0;
    while (results.size() < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    n_tests++;
    if (results.size() !== n) begin
      n_fail++;
      $display("FAIL result_count: got %0d results, expected %0d", results.size(), n);
    end
  endtask

  task automatic check_frame_results(input string tag);
    logic [7:0] exp_res [4];
    exp_res = '{8'd5, 8'd6, 8'd9, 8'd10};
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= results.size()) begin
        n_fail++;
        $display("FAIL %s_result%0d: missing, expected %0d", tag, i, exp_res[i]);
      end else if (results[i] !== exp_res[i]) begin
        n_fail++;
        $display("FAIL %s_result%0d: got %0d expected %0d", tag, i, results[i], exp_res[i]);
      end
    end
    n_tests++;
    if (n_fd !== 1 || fd_at !== 4) begin
      n_fail++;
      $display("FAIL %s_frame_done: got %0d pulses after %0d results, expected 1 after 4", tag, n_fd, fd_at);
    end
  endtask

  task automatic test_reset();
    rst = 1; i_pixel_valid = 1; i_pixel = 8'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (o_pixel_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready: got %b expected 0", o_pixel_ready);
    end
    n_tests++;
    if ({o_gradient_start, o_result_valid, o_frame_done, o_timeout_err} !== 4'b0 || o_result !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_outputs: got start/valid/done/err %b%b%b%b result %0d, expected all 0",
               o_gradient_start, o_result_valid, o_frame_done, o_timeout_err, o_result);
    end
    n_tests++;
    if ({p0, p1, p2, p3, p4, p5, p6, p7, p8} !== 72'd0) begin
      n_fail++; $display("FAIL rst_window: got %h expected 0", {p0, p1, p2, p3, p4, p5, p6, p7, p8});
    end
    @(posedge clk); #1;
    rst = 0; i_pixel_valid = 0;
    @(negedge clk);
    n_tests++;
    if (o_pixel_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_release_ready: got %b expected 1", o_pixel_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_frame();
    clear_mon();
    stream(0, 15);
    wait_done(4);
    n_tests++;
    if (first_after !== 10) begin
      n_fail++; $display("FAIL first_start_pixel: got %0d expected 10", first_after);
    end
    n_tests++;
    if (first_win !== {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}) begin
      n_fail++; $display("FAIL first_window: got %h expected 000102040506080 90a", first_win);
    end
    n_tests++;
    if (n_start !== 4) begin
      n_fail++; $display("FAIL start_count: got %0d expected 4", n_start);
    end
    check_frame_results("frame");
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int cyc = 0;
    clear_mon();
    i_result_ready = 0;
    fork
      stream(0, 15);
      begin
        while (!o_result_valid && cyc < 200) begin
          @(negedge clk);
          cyc++;
        end
        repeat (10) begin
          if (o_result_valid !== 1'b1 || o_result !== 8'd5 || o_pixel_ready !== 1'b0 || n_start !== 1)
            bad++;
          @(negedge clk);
        end
        @(posedge clk); #1;
        i_result_ready = 1;
      end
    join
    n_tests++;
    if (cyc >= 200 || bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d bad stall cycles (wait %0d), required valid=1 result=5 ready=0 starts=1", bad, cyc);
    end
    wait_done(4);
    check_frame_results("stall");
  endtask

  task automatic test_idle_strobe();
    int bad = 0;
    man_sum = 8'hAA;
    man_strobe = 1;
    @(posedge clk); #1;
    man_strobe = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_result_valid !== 1'b0 || o_pixel_ready !== 1'b1 || o_gradient_start !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL idle_strobe_state: %0d cycles left IDLE, required 0", bad);
    end
    n_tests++;
    if (o_result !== 8'd10) begin
      n_fail++; $display("FAIL idle_strobe_result: got %0d expected 10", o_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    int cyc = 0;
    int bad = 0;
    int strobes_before;
    clear_mon();
    stream(0, 11);
    while (n_start < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (results.size() !== 1) begin
      n_fail++; $display("FAIL pre_reset_results: got %0d expected 1", results.size());
    end
    strobes_before = mdl_strobes;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_tests++;
    if (o_pixel_ready !== 1'b1 || o_result_valid !== 1'b0 || o_result !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_state: got ready %b valid %b result %0d, expected 1 0 0",
               o_pixel_ready, o_result_valid, o_result);
    end
    repeat (20) begin
      @(negedge clk);
      if (o_result_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (mdl_strobes !== strobes_before + 1 || bad != 0 || o_result !== 8'd0) begin
      n_fail++;
      $display("FAIL late_strobe: strobes %0d, valid cycles %0d, result %0d; required 1 strobe, 0 valid, result 0",
               mdl_strobes - strobes_before, bad, o_result);
    end
    @(posedge clk); #1;
    clear_mon();
    stream(0, 15);
    wait_done(4);
    check_frame_results("after_rst");
  endtask

`ifdef FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 0;
    clear_mon();
    model_en = 0;
    stream(0, 10);
    @(negedge clk);
    n_tests++;
    if (o_gradient_start !== 1'b1) begin
      n_fail++; $display("FAIL timeout_start: got %b expected 1", o_gradient_start);
    end
    while (!o_result_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc !== 64 || o_result !== 8'd0 || o_timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fire: valid after %0d cycles result %0d err %b, expected 64 0 1",
               cyc, o_result, o_timeout_err);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (o_timeout_err !== 1'b1 || o_result_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_sticky: err %b valid %b, expected 1 0", o_timeout_err, o_result_valid);
    end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_tests++;
    if (o_timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got %b expected 0", o_timeout_err);
    end
    model_en = 1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    model_en = 1; man_strobe = 0; man_sum = 0;
    i_result_ready = 1; i_pixel = 0; i_pixel_valid = 0; rst = 1;
    last_acc = 0;
    clear_mon();
    test_reset();
    test_frame();
    test_idle_strobe();
    test_backpressure();
    test_reset_in_wait();
`ifdef FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_feeder.md
Name: sobel_window_feeder

Overview:
Upstream companion of the gradient (edge detection) unit. It accepts a raster-order 8-bit pixel stream and buffers the two previous image rows. For each interior pixel it presents a 3x3 window on P0..P8 and pulses start to the gradient unit. It then captures the returned 8-bit sum on the gradient unit's data-ready strobe and emits it as an output result stream with valid/ready handshake.

Parameters:
IMG_WIDTH, 16, pixels per row (>=3)
IMG_HEIGHT, 16, rows per frame (>=3)
TIMEOUT_CYCLES, 63, maximum WAIT cycles before timeout (used only with FEEDER_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_pixel_valid  in  1  input pixel valid
i_pixel  in  8  input pixel, raster order
o_pixel_ready  out  1  feeder can accept a pixel
o_gradient_start  out  1  one-cycle start pulse to the gradient unit
o_P0..o_P8  out  8 each  window, row-major; P0 = top-left (oldest row), P8 = bottom-right (newest pixel)
i_gradient_data_ready  in  1  gradient result strobe
i_processed_sum  in  8  gradient result, sampled when the strobe is high
o_result_valid  out  1  result available
o_result  out  8  result pixel
i_result_ready  in  1  downstream accepts the result
o_frame_done  out  1  one-cycle pulse when the last result of a frame is accepted
o_timeout_err  out  1  sticky error flag (FEEDER_TIMEOUT_EN only)

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all clocked state is updated only on the rising edge of clk.
- Reset values: state IDLE; col and row counters 0; both line buffers and all 9 window registers 0; o_gradient_start, o_result_valid, o_frame_done and o_timeout_err all 0; o_result 0.
- o_pixel_ready = (state==IDLE) && !rst.
- Accept occurs when i_pixel_valid && o_pixel_ready.
- On accept:
  - The window shifts left one column. The new right column is {line2[col], line1[col], i_pixel}, top to bottom.
  - line2[col] <= line1[col]; line1[col] <= i_pixel.
  - col increments. At IMG_WIDTH-1 it wraps to 0 and row increments. At the last pixel of the frame, row also wraps to 0.
- Window valid: the pre-increment counters satisfy row>=2 && col>=2. Each frame therefore yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) results; border pixels produce no output.
- FSM states: IDLE, START, WAIT, OUTPUT.
  - IDLE: an accept with a valid window goes to START. An accept without a valid window stays in IDLE.
  - START: o_gradient_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: when i_gradient_data_ready=1, register i_processed_sum into o_result and go to OUTPUT.
  - OUTPUT: o_result_valid=1 and o_result is held stable until i_result_ready=1. The next cycle returns to IDLE.
- o_P0..o_P8 are held constant from START through OUTPUT, because no accepts occur outside IDLE.
- Latency: the start pulse occurs 1 cycle after the accept. The result is valid 1 cycle after the data-ready strobe.
- o_frame_done pulses in the cycle after the OUTPUT handshake for the frame's last window (row H-1, col W-1).
- i_gradient_data_ready is ignored in IDLE, START and OUTPUT; stray strobes are dropped.
- Reset mid-operation: abandon everything and return to reset values. A late strobe from the gradient unit lands in IDLE and is ignored.
- i_result_ready may stay high permanently, giving a 1-cycle OUTPUT. i_pixel_valid may be held high with changing data; only accepted pixels count.

Optional Feature:
FEEDER_TIMEOUT_EN defined:
- A WAIT-cycle counter starts at 0 on WAIT entry.
- If TIMEOUT_CYCLES elapse with no strobe: o_result=8'd0, o_timeout_err set (sticky until rst), go to OUTPUT.

FEEDER_TIMEOUT_EN undefined:
- WAIT is unbounded. No counter logic is built, and o_timeout_err is tied 0.

Test Plan:
1. rst high for 3 cycles while i_pixel_valid=1 -> all outputs 0, o_pixel_ready 0. In the cycle after rst falls, o_pixel_ready=1.
2. IMG_WIDTH=IMG_HEIGHT=4. Stream pixels 0..15 with i_pixel_valid held high. The gradient model strobes 14 cycles after start and returns P4. Expect:
   - first start after pixel 10, with P0..P8 = 0,1,2,4,5,6,8,9,10;
   - exactly 4 starts, results 5,6,9,10;
   - o_frame_done once, after result 10.
3. Same stream with i_result_ready low for 10 cycles at the first result -> o_result_valid stays 1, o_result stays 5, o_pixel_ready stays 0, no second start until the handshake completes.
4. i_gradient_data_ready pulsed while in IDLE, with i_processed_sum=8'hAA -> no o_result_valid, state unchanged.
5. rst pulsed during WAIT of the second window, then a fresh 0..15 stream -> 4 results 5,6,9,10. The gradient strobe that lands after the reset produces no output.
6. FEEDER_TIMEOUT_EN, TIMEOUT_CYCLES=63, gradient model never strobes -> o_result_valid with o_result=0 after 63 WAIT cycles, o_timeout_err=1 and remains set until rst.
